// File: rtl/keccak_pkg.sv
// Shared Keccak constants that do not depend on the number of masking shares.
package keccak_pkg;

    localparam int LANES   = 25;
    localparam int ROUND_W = 5;

    // Keccak-p round count for lane width w: 12 + 2*log2(w)
    function automatic int keccakRounds(input int w);
        return 12 + 2 * $clog2(w);
    endfunction

endpackage

// File: rtl/keccak_share_compress_if.sv
// Handshake bundle between the share-compression pipeline and its surroundings.
interface keccak_share_compress_if
    import keccak_pkg::*;
#(
    parameter int SHARES = 2,
    parameter int W      = 8
);

    logic                              abort;
    logic [SHARES*SHARES*LANES*W-1:0]  inData;
    logic                              inValid;
    logic                              inReady;
    logic [SHARES*LANES*W-1:0]         outData;
    logic                              outValid;
    logic                              outReady;
    logic [ROUND_W-1:0]                outRound;
    logic                              outLast;

    modport master (
        output abort, inData, inValid, outReady,
        input  inReady, outData, outValid, outRound, outLast
    );

    modport slave (
        input  abort, inData, inValid, outReady,
        output inReady, outData, outValid, outRound, outLast
    );

endinterface

// File: rtl/keccak_share_compress_core.sv
// Two-stage elastic pipeline: stage A holds the expanded shares, stage B the compressed state.
module keccak_share_compress_core
    import keccak_pkg::*;
#(
    parameter int SHARES = 2,
    parameter int W      = 8,
    parameter int ROUNDS = 18
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    keccak_share_compress_if.slave  bus
);

    localparam int SHARE_BITS = LANES * W;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

    logic                                  aValid_q;
    logic [SHARES*SHARES*SHARE_BITS-1:0]   aData_q;
    logic [ROUND_W-1:0]                    aRound_q;
    logic                                  bValid_q;
    logic [SHARES*SHARE_BITS-1:0]          bData_q;
    logic [ROUND_W-1:0]                    bRound_q;
    logic                                  bLast_q;
    logic [ROUND_W-1:0]                    roundCnt_q;
    logic [ROUND_W-1:0]                    roundCnt_d;
    logic [SHARES*SHARE_BITS-1:0]          xorData;
    logic                                  bAdvance;
    logic                                  aAdvance;
    logic                                  accept;

    assign bAdvance     = !bValid_q || bus.outReady;
    assign aAdvance     = !aValid_q || bAdvance;
    assign bus.inReady  = !rst_i && !bus.abort && aAdvance;
    assign accept       = bus.inValid && bus.inReady;
    assign roundCnt_d   = (roundCnt_q == LAST_ROUND) ? '0 : roundCnt_q + 1'b1;

    // Output share j folds stage-A shares j*SHARES .. j*SHARES+SHARES-1, which sit contiguously.
    for (genvar j = 0; j < SHARES; j++) begin : g_share
        keccak_share_xor #(.SHARES(SHARES), .W(W)) u_xor (
            .shares_i (aData_q[j*SHARES*SHARE_BITS +: SHARES*SHARE_BITS]),
            .sum_o    (xorData[j*SHARE_BITS +: SHARE_BITS])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aValid_q   <= 1'b0;
            aData_q    <= '0;
            aRound_q   <= '0;
            bValid_q   <= 1'b0;
            bData_q    <= '0;
            bRound_q   <= '0;
            bLast_q    <= 1'b0;
            roundCnt_q <= '0;
        end else if (bus.abort) begin
            // Abort empties the pipe but leaves data registers untouched to avoid needless toggling.
            aValid_q   <= 1'b0;
            bValid_q   <= 1'b0;
            roundCnt_q <= '0;
        end else begin
            if (aAdvance) begin
                aValid_q <= accept;
            end
            if (accept) begin
                aData_q    <= bus.inData;
                aRound_q   <= roundCnt_q;
                roundCnt_q <= roundCnt_d;
            end
            if (bAdvance) begin
                bValid_q <= aValid_q;
            end
            if (bAdvance && aValid_q) begin
                bData_q  <= xorData;
                bRound_q <= aRound_q;
                bLast_q  <= (aRound_q == LAST_ROUND);
            end
        end
    end

    assign bus.outData  = bData_q;
    assign bus.outValid = bValid_q;
    assign bus.outRound = bRound_q;
    assign bus.outLast  = bLast_q;

endmodule

// File: rtl/keccak_share_xor.sv
// Folds SHARES expanded shares into one output share by bitwise XOR.
module keccak_share_xor
    import keccak_pkg::*;
#(
    parameter int SHARES = 2,
    parameter int W      = 8
) (
    input  logic [SHARES*LANES*W-1:0] shares_i,
    output logic [LANES*W-1:0]        sum_o
);

    always_comb begin
        sum_o = '0;
        for (int k = 0; k < SHARES; k++) begin
            sum_o = sum_o ^ shares_i[k*LANES*W +: LANES*W];
        end
    end

endmodule

// File: rtl/keccak_share_compress.sv
// Share compression stage after masked chi/iota: SHARES**2 expanded shares in, SHARES shares out.
module keccak_share_compress
    import keccak_pkg::*;
#(
    parameter int SHARES = 2,
    parameter int W      = 8
) (
    input  logic                              ClkxCI,
    input  logic                              RstxRI,
    input  logic                              AbortxSI,
    input  logic [SHARES*SHARES*LANES*W-1:0]  In,
    input  logic                              InValidxSI,
    output logic                              InReadyxSO,
    output logic [SHARES*LANES*W-1:0]         Out,
    output logic                              OutValidxSO,
    input  logic                              OutReadyxSI,
    output logic [ROUND_W-1:0]                OutRoundxDO,
    output logic                              OutLastxSO
);

    localparam int ROUNDS = keccakRounds(W);

    keccak_share_compress_if #(.SHARES(SHARES), .W(W)) bus ();

    assign bus.abort    = AbortxSI;
    assign bus.inData   = In;
    assign bus.inValid  = InValidxSI;
    assign bus.outReady = OutReadyxSI;
    assign InReadyxSO   = bus.inReady;
    assign Out          = bus.outData;
    assign OutValidxSO  = bus.outValid;
    assign OutRoundxDO  = bus.outRound;
    assign OutLastxSO   = bus.outLast;

    keccak_share_compress_core #(.SHARES(SHARES), .W(W), .ROUNDS(ROUNDS)) u_core (
        .clk_i (ClkxCI),
        .rst_i (RstxRI),
        .bus   (bus.slave)
    );

endmodule
